// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared parameters and types for the frame buffer access arbiter
package fb_arb_pkg;
   localparam int FB_WIDTH   = 640;
   localparam int FB_HEIGHT  = 480;
   localparam int FB_COLOR_W = 4;
   localparam int FB_ADDR_W  = 19;
   localparam int PIXELS     = FB_WIDTH * FB_HEIGHT;
   localparam int X_W        = 10;
   localparam int Y_W        = 9;

   typedef enum logic {ARB, CLEAR} arb_state_t;
   typedef enum logic {GNT_PRU, GNT_CPU} grant_t;
endpackage

// File: rtl/fb_xy_to_addr.sv
// rtl/fb_xy_to_addr.sv - (x, y) to linear frame buffer address with range flag
module fb_xy_to_addr
   import fb_arb_pkg::*;
#(
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT,
   parameter int ADDR_W = FB_ADDR_W
) (
   input  logic [X_W-1:0]    i_x,
   input  logic [Y_W-1:0]    i_y,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_in_range
);
   // Product is formed at 32 bits so out-of-range coordinates wrap predictably.
   assign o_addr     = ADDR_W'(32'(i_y) * 32'(WIDTH) + 32'(i_x));
   assign o_in_range = (32'(i_x) < 32'(WIDTH)) && (32'(i_y) < 32'(HEIGHT));
endmodule

// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - PRU/CPU pixel port arbiter with full-screen clear sequencer
module fb_access_arbiter
   import fb_arb_pkg::*;
#(
   parameter int WIDTH   = FB_WIDTH,
   parameter int HEIGHT  = FB_HEIGHT,
   parameter int COLOR_W = FB_COLOR_W,
   parameter int ADDR_W  = FB_ADDR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pru_req,
   input  logic [X_W-1:0]     pru_x,
   input  logic [Y_W-1:0]     pru_y,
   input  logic [COLOR_W-1:0] pru_color,
   output logic               pru_ack,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [X_W-1:0]     cpu_x,
   input  logic [Y_W-1:0]     cpu_y,
   input  logic [COLOR_W-1:0] cpu_wdata,
   output logic               cpu_ack,
   output logic [COLOR_W-1:0] cpu_rdata,
   input  logic               clr_start,
   input  logic [COLOR_W-1:0] clr_color,
   output logic               clr_busy,
   output logic               clr_done,
   output logic               oob_drop,
   output logic               fb_we,
   output logic               fb_re,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_wdata,
   input  logic [COLOR_W-1:0] fb_rdata
);
   localparam int unsigned       L_PIXELS    = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] L_LAST_ADDR = ADDR_W'(L_PIXELS - 1);

   arb_state_t         r_state, w_state_nxt;
   grant_t             r_last;
   logic               r_pru_ack, r_cpu_ack, r_oob, r_fb_we, r_fb_re, r_rd_pend, r_clr_done;
   logic [ADDR_W-1:0]  r_fb_addr, r_clr_cnt;
   logic [COLOR_W-1:0] r_fb_wdata, r_clr_color, r_cpu_rdata;

   logic [ADDR_W-1:0]  w_pru_addr, w_cpu_addr;
   logic               w_pru_inr, w_cpu_inr;
   logic               w_pru_elig, w_cpu_elig;
   logic               w_gnt_pru, w_gnt_cpu, w_clr_accept, w_clr_last;

   fb_xy_to_addr #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_pru_xy (
      .i_x(pru_x), .i_y(pru_y), .o_addr(w_pru_addr), .o_in_range(w_pru_inr)
   );

   fb_xy_to_addr #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_cpu_xy (
      .i_x(cpu_x), .i_y(cpu_y), .o_addr(w_cpu_addr), .o_in_range(w_cpu_inr)
   );

   // A requester whose ack is showing (or CPU read still in flight) sits out one round.
   assign w_pru_elig = pru_req && !r_pru_ack;
   assign w_cpu_elig = cpu_req && !r_cpu_ack && !r_rd_pend;

   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_pru    = 1'b0;
      w_gnt_cpu    = 1'b0;
      w_clr_accept = 1'b0;
      w_clr_last   = 1'b0;
      case (r_state)
         ARB: begin
            if (clr_start) begin
               w_clr_accept = 1'b1;
               w_state_nxt  = CLEAR;
            end else if (w_pru_elig && w_cpu_elig) begin
               w_gnt_cpu = (r_last == GNT_PRU);
               w_gnt_pru = (r_last == GNT_CPU);
            end else begin
               w_gnt_pru = w_pru_elig;
               w_gnt_cpu = w_cpu_elig;
            end
         end
         CLEAR: begin
            w_clr_last = (r_clr_cnt == L_LAST_ADDR);
            if (w_clr_last) w_state_nxt = ARB;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ARB;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last      <= GNT_PRU;
         r_pru_ack   <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_oob       <= 1'b0;
         r_fb_we     <= 1'b0;
         r_fb_re     <= 1'b0;
         r_fb_addr   <= '0;
         r_fb_wdata  <= '0;
         r_rd_pend   <= 1'b0;
         r_clr_cnt   <= '0;
         r_clr_color <= '0;
         r_clr_done  <= 1'b0;
      end else begin
         r_pru_ack  <= w_gnt_pru;
         r_cpu_ack  <= 1'b0;
         r_oob      <= 1'b0;
         r_fb_we    <= 1'b0;
         r_fb_re    <= 1'b0;
         r_rd_pend  <= 1'b0;
         r_clr_done <= w_clr_last;

         // Read data is captured in the cycle fb_re is presented, independent of state.
         if (r_rd_pend) begin
            r_cpu_ack   <= 1'b1;
            r_cpu_rdata <= fb_rdata;
         end

         if (w_clr_accept) begin
            r_clr_color <= clr_color;
            r_clr_cnt   <= '0;
            r_fb_we     <= 1'b1;
            r_fb_addr   <= '0;
            r_fb_wdata  <= clr_color;
         end else if ((r_state == CLEAR) && !w_clr_last) begin
            r_clr_cnt   <= r_clr_cnt + 1'b1;
            r_fb_we     <= 1'b1;
            r_fb_addr   <= r_clr_cnt + 1'b1;
            r_fb_wdata  <= r_clr_color;
         end

         if (w_gnt_pru) begin
            r_last <= GNT_PRU;
            r_oob  <= !w_pru_inr;
            if (w_pru_inr) begin
               r_fb_we    <= 1'b1;
               r_fb_addr  <= w_pru_addr;
               r_fb_wdata <= pru_color;
            end
         end

         if (w_gnt_cpu) begin
            r_last <= GNT_CPU;
            r_oob  <= !w_cpu_inr;
            if (!w_cpu_inr) begin
               r_cpu_ack <= 1'b1;
               if (!cpu_we) r_cpu_rdata <= '0;
            end else if (cpu_we) begin
               r_cpu_ack  <= 1'b1;
               r_fb_we    <= 1'b1;
               r_fb_addr  <= w_cpu_addr;
               r_fb_wdata <= cpu_wdata;
            end else begin
               r_fb_re   <= 1'b1;
               r_fb_addr <= w_cpu_addr;
               r_rd_pend <= 1'b1;
            end
         end
      end
   end

   assign pru_ack   = r_pru_ack;
   assign cpu_ack   = r_cpu_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign clr_busy  = (r_state == CLEAR);
   assign clr_done  = r_clr_done;
   assign oob_drop  = r_oob;
   assign fb_we     = r_fb_we;
   assign fb_re     = r_fb_re;
   assign fb_addr   = r_fb_addr;
   assign fb_wdata  = r_fb_wdata;
endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb/tb_fb_access_arbiter.sv - directed and randomized checks of fb_access_arbiter
module tb_fb_access_arbiter;
   localparam int W_A = 640, H_A = 480, PIX_A = W_A * H_A;
   localparam int CW = 4, AW = 19;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Full-size instance
   logic          pru_req_a = 0, cpu_req_a = 0, cpu_we_a = 0, clr_start_a = 0;
   logic [9:0]    pru_x_a = 0, cpu_x_a = 0;
   logic [8:0]    pru_y_a = 0, cpu_y_a = 0;
   logic [CW-1:0] pru_color_a = 0, cpu_wdata_a = 0, clr_color_a = 0, fb_rdata_a;
   logic          pru_ack_a, cpu_ack_a, clr_busy_a, clr_done_a, oob_drop_a, fb_we_a, fb_re_a;
   logic [CW-1:0] cpu_rdata_a, fb_wdata_a;
   logic [AW-1:0] fb_addr_a;

   // 8x4 instance for clear sequencing
   logic          pru_req_b = 0, cpu_req_b = 0, cpu_we_b = 0, clr_start_b = 0;
   logic [9:0]    pru_x_b = 0, cpu_x_b = 0;
   logic [8:0]    pru_y_b = 0, cpu_y_b = 0;
   logic [CW-1:0] pru_color_b = 0, cpu_wdata_b = 0, clr_color_b = 0, fb_rdata_b = 0;
   logic          pru_ack_b, cpu_ack_b, clr_busy_b, clr_done_b, oob_drop_b, fb_we_b, fb_re_b;
   logic [CW-1:0] cpu_rdata_b, fb_wdata_b;
   logic [AW-1:0] fb_addr_b;

   fb_access_arbiter u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .pru_req(pru_req_a), .pru_x(pru_x_a), .pru_y(pru_y_a), .pru_color(pru_color_a), .pru_ack(pru_ack_a),
      .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_x(cpu_x_a), .cpu_y(cpu_y_a), .cpu_wdata(cpu_wdata_a),
      .cpu_ack(cpu_ack_a), .cpu_rdata(cpu_rdata_a),
      .clr_start(clr_start_a), .clr_color(clr_color_a), .clr_busy(clr_busy_a), .clr_done(clr_done_a),
      .oob_drop(oob_drop_a), .fb_we(fb_we_a), .fb_re(fb_re_a), .fb_addr(fb_addr_a),
      .fb_wdata(fb_wdata_a), .fb_rdata(fb_rdata_a)
   );

   fb_access_arbiter #(.WIDTH(8), .HEIGHT(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .pru_req(pru_req_b), .pru_x(pru_x_b), .pru_y(pru_y_b), .pru_color(pru_color_b), .pru_ack(pru_ack_b),
      .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_x(cpu_x_b), .cpu_y(cpu_y_b), .cpu_wdata(cpu_wdata_b),
      .cpu_ack(cpu_ack_b), .cpu_rdata(cpu_rdata_b),
      .clr_start(clr_start_b), .clr_color(clr_color_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b),
      .oob_drop(oob_drop_b), .fb_we(fb_we_b), .fb_re(fb_re_b), .fb_addr(fb_addr_b),
      .fb_wdata(fb_wdata_b), .fb_rdata(fb_rdata_b)
   );

   // Frame buffer behind instance A; data is deliberately scrambled when fb_re is low.
   logic [CW-1:0] buf_a [PIX_A];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < PIX_A; i++) buf_a[i] <= '0;
      end else if (fb_we_a && (int'(fb_addr_a) < PIX_A)) begin
         buf_a[fb_addr_a] <= fb_wdata_a;
      end
   end
   always_comb begin
      fb_rdata_a = '0;
      if (int'(fb_addr_a) < PIX_A) fb_rdata_a = fb_re_a ? buf_a[fb_addr_a] : ~buf_a[fb_addr_a];
   end

   logic [CW-1:0] model_a [PIX_A];
   int n_cmp = 0, n_bad = 0;

   logic       p_act, c_act, c_we, exp_we, exp_oob, inr;
   logic [9:0] px, cx;
   logic [8:0] py, cy;
   logic [3:0] pc, cd;
   int         p_age, c_age, addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] pick_x();
      int r = int'($urandom_range(7));
      case (r)
         4:       return 10'd638;
         5:       return 10'd639;
         6:       return 10'd640;
         7:       return 10'd1023;
         default: return 10'(r);
      endcase
   endfunction

   function automatic logic [8:0] pick_y();
      int r = int'($urandom_range(5));
      case (r)
         3:       return 9'd479;
         4:       return 9'd480;
         5:       return 9'd511;
         default: return 9'(r);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < PIX_A; i++) model_a[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_pru_ack",  32'(pru_ack_a), 0);
      check("rst_cpu_ack",  32'(cpu_ack_a), 0);
      check("rst_cpu_rdata",32'(cpu_rdata_a), 0);
      check("rst_fb_we",    32'(fb_we_a), 0);
      check("rst_fb_re",    32'(fb_re_a), 0);
      check("rst_fb_addr",  32'(fb_addr_a), 0);
      check("rst_oob",      32'(oob_drop_a), 0);
      check("rst_clr_busy", 32'(clr_busy_a), 0);
      check("rst_clr_done", 32'(clr_done_b), 0);
      rst_n = 1'b1;

      // Contention straight out of reset: CPU wins first, then strict alternation.
      pru_x_a = 1; pru_y_a = 1; pru_color_a = 3; pru_req_a = 1;
      cpu_we_a = 1; cpu_x_a = 2; cpu_y_a = 1; cpu_wdata_a = 4; cpu_req_a = 1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("cont_cpu_ack", 32'(cpu_ack_a), 32'(k % 2 == 0));
         check("cont_pru_ack", 32'(pru_ack_a), 32'(k % 2 == 1));
         check("cont_fb_addr", 32'(fb_addr_a), (k % 2 == 0) ? 642 : 641);
         check("cont_fb_wdata", 32'(fb_wdata_a), (k % 2 == 0) ? 4 : 3);
      end
      pru_req_a = 0; cpu_req_a = 0;
      model_a[641] = 3; model_a[642] = 4;
      @(negedge clk);
      check("cont_idle_acks", 32'({pru_ack_a, cpu_ack_a}), 0);

      pru_x_a = 3; pru_y_a = 2; pru_color_a = 5; pru_req_a = 1;
      @(negedge clk);
      check("pru_wr_ack",   32'(pru_ack_a), 1);
      check("pru_wr_we",    32'(fb_we_a), 1);
      check("pru_wr_addr",  32'(fb_addr_a), 1283);
      check("pru_wr_data",  32'(fb_wdata_a), 5);
      check("pru_wr_oob",   32'(oob_drop_a), 0);
      pru_req_a = 0; model_a[1283] = 5;
      @(negedge clk);
      check("pru_ack_pulse", 32'(pru_ack_a), 0);

      pru_x_a = 639; pru_y_a = 479; pru_color_a = 9; pru_req_a = 1;
      @(negedge clk);
      check("corner_wr_addr", 32'(fb_addr_a), 307199);
      pru_req_a = 0; model_a[307199] = 9;
      cpu_we_a = 0; cpu_x_a = 639; cpu_y_a = 479; cpu_req_a = 1;
      @(negedge clk);
      check("rd_fb_re",    32'(fb_re_a), 1);
      check("rd_fb_addr",  32'(fb_addr_a), 307199);
      check("rd_early_ack",32'(cpu_ack_a), 0);
      @(negedge clk);
      check("rd_ack",      32'(cpu_ack_a), 1);
      check("rd_data",     32'(cpu_rdata_a), 9);
      check("rd_fb_re_off",32'(fb_re_a), 0);
      cpu_x_a = 5; cpu_y_a = 480;
      @(negedge clk);
      @(negedge clk);
      check("oob_rd_ack",  32'(cpu_ack_a), 1);
      check("oob_rd_drop", 32'(oob_drop_a), 1);
      check("oob_rd_data", 32'(cpu_rdata_a), 0);
      check("oob_rd_re",   32'(fb_re_a), 0);
      cpu_req_a = 0;

      pru_x_a = 640; pru_y_a = 0; pru_color_a = 7; pru_req_a = 1;
      @(negedge clk);
      check("oob_wr_ack",  32'(pru_ack_a), 1);
      check("oob_wr_drop", 32'(oob_drop_a), 1);
      check("oob_wr_we",   32'(fb_we_a), 0);
      pru_req_a = 0;
      cpu_we_a = 0; cpu_x_a = 0; cpu_y_a = 1; cpu_req_a = 1;
      @(negedge clk);
      @(negedge clk);
      check("oob_wr_buf_ack",  32'(cpu_ack_a), 1);
      check("oob_wr_buf_data", 32'(cpu_rdata_a), 0);
      cpu_req_a = 0;
      @(negedge clk);

      // Randomized traffic against a pixel-level model of the buffer.
      p_act = 0; c_act = 0; p_age = 0; c_age = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!p_act && cyc < 560 && $urandom_range(3) != 0) begin
            p_act = 1; p_age = 0; px = pick_x(); py = pick_y(); pc = 4'($urandom);
            pru_x_a = px; pru_y_a = py; pru_color_a = pc; pru_req_a = 1;
         end
         if (!c_act && cyc < 560 && $urandom_range(3) != 0) begin
            c_act = 1; c_age = 0; cx = pick_x(); cy = pick_y(); cd = 4'($urandom); c_we = 1'($urandom);
            cpu_x_a = cx; cpu_y_a = cy; cpu_wdata_a = cd; cpu_we_a = c_we; cpu_req_a = 1;
         end
         @(negedge clk);
         p_age++; c_age++;
         exp_we = 0; exp_oob = 0;
         // CPU first: a read acked now sampled the buffer before any write acked now.
         if (cpu_ack_a) begin
            check("rnd_cpu_ack_owed", 32'(c_act), 1);
            inr  = (cx < 640) && (cy < 480);
            addr = int'(cy) * 640 + int'(cx);
            if (c_we) begin
               if (inr) begin
                  exp_we = 1;
                  check("rnd_cpu_wr_addr", 32'(fb_addr_a), 32'(addr));
                  check("rnd_cpu_wr_data", 32'(fb_wdata_a), 32'(cd));
                  model_a[addr] = cd;
               end else exp_oob = 1;
            end else begin
               check("rnd_cpu_rd_data", 32'(cpu_rdata_a), inr ? 32'(model_a[addr]) : 0);
               if (!inr) exp_oob = 1;
            end
            c_act = 0; cpu_req_a = 0;
         end
         if (pru_ack_a) begin
            check("rnd_pru_ack_owed", 32'(p_act), 1);
            inr  = (px < 640) && (py < 480);
            addr = int'(py) * 640 + int'(px);
            if (inr) begin
               exp_we = 1;
               check("rnd_pru_wr_addr", 32'(fb_addr_a), 32'(addr));
               check("rnd_pru_wr_data", 32'(fb_wdata_a), 32'(pc));
               model_a[addr] = pc;
            end else exp_oob = 1;
            p_act = 0; pru_req_a = 0;
         end
         check("rnd_fb_we",  32'(fb_we_a), 32'(exp_we));
         check("rnd_oob",    32'(oob_drop_a), 32'(exp_oob));
         check("rnd_timeout",32'((p_act && p_age > 10) || (c_act && c_age > 10)), 0);
      end
      check("rnd_drained", 32'({p_act, c_act}), 0);

      // Clear on the 8x4 instance with a PRU request arriving in the same cycle.
      pru_x_b = 1; pru_y_b = 0; pru_color_b = 6; pru_req_b = 1;
      clr_color_b = 2; clr_start_b = 1;
      @(negedge clk);
      clr_start_b = 0;
      for (int k = 0; k < 32; k++) begin
         if (k == 4) begin clr_start_b = 1; clr_color_b = 3; end
         if (k == 5) clr_start_b = 0;
         check("clr_we",    32'(fb_we_b), 1);
         check("clr_addr",  32'(fb_addr_b), 32'(k));
         check("clr_data",  32'(fb_wdata_b), 2);
         check("clr_busy",  32'(clr_busy_b), 1);
         check("clr_no_gnt",32'({pru_ack_b, clr_done_b}), 0);
         @(negedge clk);
      end
      check("clr_done",      32'(clr_done_b), 1);
      check("clr_busy_off",  32'(clr_busy_b), 0);
      check("clr_we_off",    32'(fb_we_b), 0);
      check("clr_pru_wait",  32'(pru_ack_b), 0);
      @(negedge clk);
      check("clr_pru_ack",   32'(pru_ack_b), 1);
      check("clr_pru_addr",  32'(fb_addr_b), 1);
      check("clr_pru_data",  32'(fb_wdata_b), 6);
      check("clr_done_pulse",32'(clr_done_b), 0);
      pru_req_b = 0;

      clr_color_b = 1; clr_start_b = 1;
      @(negedge clk);
      clr_start_b = 0;
      for (int k = 0; k < 40 && fb_addr_b != 10; k++) @(negedge clk);
      check("mid_clr_addr", 32'(fb_addr_b), 10);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",  32'(clr_busy_b), 0);
      check("mid_rst_we",    32'(fb_we_b), 0);
      check("mid_rst_addr",  32'(fb_addr_b), 0);
      check("mid_rst_data",  32'(fb_wdata_b), 0);
      check("mid_rst_flags", 32'({clr_done_b, pru_ack_b, cpu_ack_b, oob_drop_b, fb_re_b}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(clr_busy_b), 0);
      check("post_rst_we",   32'(fb_we_b), 0);
      clr_color_b = 5; clr_start_b = 1;
      @(negedge clk);
      clr_start_b = 0;
      check("restart_addr",  32'(fb_addr_b), 0);
      check("restart_data",  32'(fb_wdata_b), 5);
      check("restart_busy",  32'(clr_busy_b), 1);
      @(negedge clk);
      check("restart_next",  32'(fb_addr_b), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
